// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (I) and data load/store (D).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module mem_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_ack,
    output logic [DATA_W-1:0]     i_rdata,
    output logic                  i_err,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wmask,
    output logic                  d_ack,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wmask,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0]   mem_wmask_q, mem_wmask_d;
    logic                i_ack_q, i_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                i_err_q, i_err_d;
    logic                d_err_q, d_err_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                busy_q, busy_d;

    logic                i_elig;
    logic                d_elig;
    logic                pick_d;
    logic                timeout_hit;

    // A requester still holding req during its own ack cycle is not a new request.
    assign i_elig = i_req && !i_ack_q;
    assign d_elig = d_req && !d_ack_q;

`ifdef MEM_ARB_RR_EN
    logic rr_q, rr_d;  // 1: D wins the next tie, 0: I wins

    assign pick_d = d_elig && (!i_elig || rr_q);
`else
    assign pick_d = d_elig;
`endif

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        busy_d      = busy_q;
        i_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        i_err_d     = 1'b0;
        d_err_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
`ifdef MEM_ARB_RR_EN
        rr_d        = rr_q;
`endif

        case (state_q)
            IDLE: begin
                if (i_elig || d_elig) begin
                    mem_req_d = 1'b1;
                    busy_d    = 1'b1;
                    cnt_d     = '0;
                    if (pick_d) begin
                        state_d     = GRANT_D;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                        mem_wmask_d = d_wmask;
                    end else begin
                        state_d     = GRANT_I;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = i_addr;
                        mem_wdata_d = '0;
                        mem_wmask_d = '0;
                    end
`ifdef MEM_ARB_RR_EN
                    rr_d = !pick_d;
`endif
                end
            end

            GRANT_I, GRANT_D: begin
                // mem_ready in the last allowed cycle wins over the watchdog
                if (mem_ready || timeout_hit) begin
                    state_d   = IDLE;
                    cnt_d     = '0;
                    mem_req_d = 1'b0;
                    busy_d    = 1'b0;
                    if (state_q == GRANT_D) begin
                        d_ack_d   = 1'b1;
                        d_err_d   = !mem_ready;
                        d_rdata_d = mem_ready ? mem_rdata : '0;
                    end else begin
                        i_ack_d   = 1'b1;
                        i_err_d   = !mem_ready;
                        i_rdata_d = mem_ready ? mem_rdata : '0;
                    end
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            busy_q      <= 1'b0;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            d_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
            rr_q        <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            busy_q      <= busy_d;
            i_ack_q     <= i_ack_d;
            d_ack_q     <= d_ack_d;
            i_err_q     <= i_err_d;
            d_err_q     <= d_err_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
            rr_q        <= rr_d;
`endif
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign busy      = busy_q;
    assign i_ack     = i_ack_q;
    assign d_ack     = d_ack_q;
    assign i_err     = i_err_q;
    assign d_err     = d_err_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked every cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = DW / 8;
    localparam int unsigned TO = 4;

    logic          clk       = 1'b0;
    logic          reset     = 1'b1;
    logic          i_req     = 1'b0;
    logic [AW-1:0] i_addr    = '0;
    logic          d_req     = 1'b0;
    logic          d_we      = 1'b0;
    logic [AW-1:0] d_addr    = '0;
    logic [DW-1:0] d_wdata   = '0;
    logic [MW-1:0] d_wmask   = '0;
    logic          mem_ready = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    logic          i_ack, i_err, d_ack, d_err, mem_req, mem_we, busy;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [MW-1:0] mem_wmask;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .i_err    (i_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wmask  (d_wmask),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wmask(mem_wmask),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level reference model ----------------
    bit            m_valid = 1'b0;
    logic          e_mem_req, e_we, e_i_ack, e_d_ack, e_i_err, e_d_err, e_busy, e_fchk;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata, e_i_rdata, e_d_rdata;
    logic [MW-1:0] e_wmask;
    bit            txn_on;
    bit            txn_is_d;
    int            txn_age;
`ifdef MEM_ARB_RR_EN
    bit            rr_prefer_d;
`endif

    // Compare this cycle's outputs, then predict next cycle from this cycle's inputs.
    always @(negedge clk) begin
        bit ie, de, take_d, cur_i_ack, cur_d_ack, ok, done;
        if (m_valid) begin
            chk("mem_req", 32'(mem_req), 32'(e_mem_req));
            chk("busy",    32'(busy),    32'(e_busy));
            chk("i_ack",   32'(i_ack),   32'(e_i_ack));
            chk("d_ack",   32'(d_ack),   32'(e_d_ack));
            chk("i_err",   32'(i_err),   32'(e_i_err));
            chk("d_err",   32'(d_err),   32'(e_d_err));
            chk("i_rdata", i_rdata,      e_i_rdata);
            chk("d_rdata", d_rdata,      e_d_rdata);
            if (e_mem_req || e_fchk) begin
                chk("mem_we",    32'(mem_we),    32'(e_we));
                chk("mem_addr",  mem_addr,       e_addr);
                chk("mem_wdata", mem_wdata,      e_wdata);
                chk("mem_wmask", 32'(mem_wmask), 32'(e_wmask));
            end
        end
        if (reset) begin
            m_valid   = 1'b1;
            txn_on    = 1'b0;
            e_mem_req = 1'b0; e_busy = 1'b0; e_we = 1'b0;
            e_i_ack   = 1'b0; e_d_ack = 1'b0; e_i_err = 1'b0; e_d_err = 1'b0;
            e_addr    = '0;   e_wdata = '0;  e_wmask = '0;
            e_i_rdata = '0;   e_d_rdata = '0;
            e_fchk    = 1'b1;
`ifdef MEM_ARB_RR_EN
            rr_prefer_d = 1'b1;
`endif
        end else if (m_valid) begin
            cur_i_ack = e_i_ack;
            cur_d_ack = e_d_ack;
            e_i_ack = 1'b0; e_d_ack = 1'b0; e_i_err = 1'b0; e_d_err = 1'b0;
            e_fchk  = 1'b0;
            if (txn_on) begin
                txn_age++;
                ok   = mem_ready;
                done = ok || (TO != 0 && txn_age == int'(TO));
                if (done) begin
                    txn_on    = 1'b0;
                    e_mem_req = 1'b0;
                    e_busy    = 1'b0;
                    if (txn_is_d) begin
                        e_d_ack = 1'b1; e_d_err = !ok; e_d_rdata = ok ? mem_rdata : '0;
                    end else begin
                        e_i_ack = 1'b1; e_i_err = !ok; e_i_rdata = ok ? mem_rdata : '0;
                    end
                end
            end else begin
                ie = i_req && !cur_i_ack;
                de = d_req && !cur_d_ack;
`ifdef MEM_ARB_RR_EN
                take_d = de && (!ie || rr_prefer_d);
`else
                take_d = de;
`endif
                if (ie || de) begin
                    txn_on    = 1'b1;
                    txn_is_d  = take_d;
                    txn_age   = 0;
                    e_mem_req = 1'b1;
                    e_busy    = 1'b1;
                    e_we      = take_d ? d_we    : 1'b0;
                    e_addr    = take_d ? d_addr  : i_addr;
                    e_wdata   = take_d ? d_wdata : '0;
                    e_wmask   = take_d ? d_wmask : '0;
`ifdef MEM_ARB_RR_EN
                    rr_prefer_d = !take_d;
`endif
                end
            end
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct {
        string       name;
        bit          is_d;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          wait_n;
        logic [31:0] rdata;
        int          exp_lat;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic run_vec(input vec_t v, output int lat, output logic err,
                           output logic [31:0] rd, output logic [31:0] addr_seen);
        int g;
        logic ack;
        g = 0;
        lat = -1; err = 1'bx; rd = 'x; addr_seen = 'x;
        mem_ready = 1'b0;
        if (v.is_d) begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; d_wmask = v.wmask;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        for (int k = 1; k <= 20; k++) begin
            step();
            mem_ready = 1'b0;
            ack = v.is_d ? d_ack : i_ack;
            if (ack) begin
                lat = k;
                err = v.is_d ? d_err : i_err;
                rd  = v.is_d ? d_rdata : i_rdata;
                i_req = 1'b0; d_req = 1'b0;
                return;
            end
            if (mem_req) begin
                g++;
                if (g == 1) addr_seen = mem_addr;
                if (g == v.wait_n + 1) begin
                    mem_ready = 1'b1;
                    mem_rdata = v.rdata;
                end
            end
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    logic [31:0] seen_q[$];

    // Both requesters raised together; records the address of each new memory transaction.
    task automatic run_pair(input bit hold_req, input int n_want, output int acks);
        bit prev_mreq;
        prev_mreq = 1'b0;
        acks = 0;
        seen_q.delete();
        i_req = 1'b1; i_addr = 32'h400;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h800; d_wdata = '0; d_wmask = '0;
        mem_ready = 1'b0;
        for (int k = 0; k < 60; k++) begin
            step();
            mem_ready = 1'b0;
            if (i_ack) begin
                acks++;
                if (!hold_req) i_req = 1'b0;
            end
            if (d_ack) begin
                acks++;
                if (!hold_req) d_req = 1'b0;
            end
            if (acks >= n_want) begin
                i_req = 1'b0; d_req = 1'b0;
                break;
            end
            if (mem_req) begin
                if (!prev_mreq) seen_q.push_back(mem_addr);
                mem_ready = 1'b1;
                mem_rdata = $urandom;
            end
            prev_mreq = mem_req;
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_time_limit: got still running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        vec_t        vecs[7];
        logic [31:0] exp_order[4];
        int          lat, acks;
        logic        err;
        logic [31:0] rd, aseen, act;

        vecs[0] = '{"fetch",       1'b0, 1'b0, 32'h100,  32'h0,        4'h0, 0,  32'h13,       2, 1'b0, 32'h13};
        vecs[1] = '{"store",       1'b1, 1'b1, 32'h2004, 32'hDEADBEEF, 4'h3, 3,  32'h55,       5, 1'b0, 32'h55};
        vecs[2] = '{"load_last",   1'b1, 1'b0, 32'h3000, 32'h0,        4'h0, 3,  32'hCAFEF00D, 5, 1'b0, 32'hCAFEF00D};
        vecs[3] = '{"load_to",     1'b1, 1'b0, 32'h3004, 32'h0,        4'h0, 99, 32'h77,       5, 1'b1, 32'h0};
        vecs[4] = '{"fetch_after", 1'b0, 1'b0, 32'h108,  32'h0,        4'h0, 2,  32'h0BADC0DE, 4, 1'b0, 32'h0BADC0DE};
        vecs[5] = '{"fetch_to",    1'b0, 1'b0, 32'h10C,  32'h0,        4'h0, 99, 32'h1,        5, 1'b1, 32'h0};
        vecs[6] = '{"load_w1",     1'b1, 1'b0, 32'h40,   32'h0,        4'h0, 1,  32'h12345678, 3, 1'b0, 32'h12345678};

        exp_order[0] = 32'h800; exp_order[1] = 32'h400;
        exp_order[2] = 32'h800; exp_order[3] = 32'h400;

        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        chk("rst_mem_req", 32'(mem_req), 32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_addr",    mem_addr,     32'h0);
        step();

        for (int n = 0; n < 7; n++) begin
            run_vec(vecs[n], lat, err, rd, aseen);
            chk({vecs[n].name, "_latency"}, 32'(lat), 32'(vecs[n].exp_lat));
            chk({vecs[n].name, "_err"},     32'(err), 32'(vecs[n].exp_err));
            chk({vecs[n].name, "_rdata"},   rd,       vecs[n].exp_rdata);
            chk({vecs[n].name, "_addr"},    aseen,    vecs[n].addr);
            step();
            step();
        end

        // Simultaneous requests that drop after their ack: D first, then I.
        reset = 1'b1; step(); reset = 1'b0; step();
        run_pair(1'b0, 2, acks);
        chk("pair_acks", 32'(acks), 32'd2);
        chk("pair_txns", 32'(seen_q.size()), 32'd2);
        for (int i = 0; i < 2; i++) begin
            act = (i < seen_q.size()) ? seen_q[i] : 32'hFFFFFFFF;
            chk($sformatf("pair_order%0d", i), act, exp_order[i]);
        end
        step(); step();

        // Both requesters re-requesting continuously: alternating D, I, D, I.
        reset = 1'b1; step(); reset = 1'b0; step();
        run_pair(1'b1, 4, acks);
        chk("hold_acks", 32'(acks), 32'd4);
        chk("hold_txns", 32'(seen_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            act = (i < seen_q.size()) ? seen_q[i] : 32'hFFFFFFFF;
            chk($sformatf("hold_order%0d", i), act, exp_order[i]);
        end
        repeat (6) step();

        // Reset in the second grant cycle of a fetch; held request is re-issued afterwards.
        i_req = 1'b1; i_addr = 32'h500; mem_ready = 1'b0;
        step();
        chk("mid_grant1", 32'(mem_req), 32'h1);
        step();
        chk("mid_grant2", 32'(mem_req), 32'h1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_req",  32'(mem_req), 32'h0);
        chk("mid_rst_ack",  32'(i_ack),   32'h0);
        chk("mid_rst_busy", 32'(busy),    32'h0);
        chk("mid_rst_addr", mem_addr,     32'h0);
        step();
        chk("mid_reissue_req",  32'(mem_req), 32'h1);
        chk("mid_reissue_addr", mem_addr,     32'h500);
        mem_ready = 1'b1; mem_rdata = 32'hA5A5_0001;
        step();
        mem_ready = 1'b0;
        chk("mid_reissue_ack",   32'(i_ack), 32'h1);
        chk("mid_reissue_rdata", i_rdata,    32'hA5A5_0001);
        i_req = 1'b0;
        repeat (3) step();

        // Randomized traffic with random memory latency, timeouts and occasional resets.
        for (int c = 0; c < 3000; c++) begin
            step();
            reset     = ($urandom_range(0, 299) == 0);
            mem_ready = mem_req && ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
            if (i_req) begin
                if (i_ack && $urandom_range(0, 1) == 1) i_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                i_req = 1'b1; i_addr = $urandom;
            end
            if (d_req) begin
                if (d_ack && $urandom_range(0, 1) == 1) d_req = 1'b0;
            end else if ($urandom_range(0, 2) == 0) begin
                d_req = 1'b1; d_we = 1'($urandom); d_addr = $urandom;
                d_wdata = $urandom; d_wmask = 4'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                i_addr = $urandom; d_addr = $urandom; d_wdata = $urandom;
                d_wmask = 4'($urandom); d_we = 1'($urandom);
            end
        end
        reset = 1'b0; mem_ready = 1'b0; i_req = 1'b0; d_req = 1'b0;
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single memory port between two requesters: instruction fetch (I) and data load/store (D).
- Sits between the step-sequenced control/datapath and the memory.
- One transaction is outstanding at a time; the granted request's fields are registered and held stable until memory responds.
- A response watchdog aborts hung transactions with an error flag.

Parameters:
- ADDR_W, 32, address width of the requester and memory ports.
- DATA_W, 32, data width; the mask width is DATA_W/8.
- TIMEOUT, 64, max cycles in a grant state without mem_ready before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- i_req  in  1  fetch request; held high until i_ack.
- i_addr  in  ADDR_W  fetch address.
- i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  out  DATA_W  fetched word.
- i_err  out  1  valid with i_ack: watchdog abort.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_wmask  in  DATA_W/8  byte enables for stores.
- d_ack  out  1  one-cycle pulse: data access complete.
- d_rdata  out  DATA_W  load data.
- d_err  out  1  valid with d_ack: watchdog abort.
- mem_req  out  1  memory request.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_wmask  out  DATA_W/8  memory byte enables.
- mem_ready  in  1  memory completes the current request this cycle; mem_rdata valid.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high in grant states.

Behaviour:
- Reset:
  - State IDLE; timeout counter 0; RR pointer = D.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_wmask, i_ack, d_ack, i_err, d_err, i_rdata, d_rdata, busy.
  - Reset mid-transaction drops mem_req on the next edge and issues no ack.
- States: IDLE, GRANT_I, GRANT_D.
- IDLE:
  - A requester is eligible if its req = 1 and its ack output is 0 this cycle. This prevents re-granting a requester that has not yet dropped req after its ack.
  - Select the winner per the priority rule below.
  - Register the winner's fields into the mem_* outputs. Fetches register mem_we = 0, wdata = 0, wmask = 0.
  - Go to GRANT_I or GRANT_D; mem_req = 1 and busy = 1 from the next cycle.
  - Latency: req seen in IDLE in cycle N gives mem_req in cycle N+1.
- GRANT_x:
  - mem_req and all mem_* fields are held constant.
  - Requester inputs are ignored; changes mid-grant have no effect.
  - On mem_ready = 1:
    - Capture mem_rdata into x_rdata. Stores also update d_rdata with mem_rdata; the value is don't-care to the requester.
    - x_ack = 1 and x_err = 0 in the next cycle.
    - mem_req = 0, busy = 0, return to IDLE, clear the counter.
  - Minimum transaction: req in N, mem_req N+1, mem_ready N+1, ack N+2.
- Watchdog (TIMEOUT > 0):
  - The counter increments each grant cycle without mem_ready.
  - If mem_ready is still 0 in the TIMEOUT-th grant cycle: next cycle x_ack = 1, x_err = 1, x_rdata = 0, mem_req = 0, return to IDLE.
  - mem_ready in exactly the TIMEOUT-th cycle counts as a success, not a timeout.
- Pulse rules:
  - ack and err are single-cycle and cleared the following cycle.
  - x_rdata holds its value until the next completion for x.
- Priority (default, macro undefined): fixed, D over I. With simultaneous eligible requests, D wins and I waits.
- The block never has two grants active and never asserts both acks in one cycle.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - With both eligible, grant the requester indicated by the RR pointer.
  - After each grant, the pointer moves to the other requester.
  - A single eligible requester is always granted immediately.
- Undefined: fixed D > I priority, no pointer state.

Test Plan:
- Fetch alone: i_req = 1, i_addr = 0x100, mem_ready on the first grant cycle with rdata = 0x00000013 -> mem_req/mem_addr = 0x100 in cycle N+1, i_ack with i_rdata = 0x13 in N+2, i_err = 0.
- Store alone: d_we = 1, d_addr = 0x2004, d_wdata = 0xDEADBEEF, d_wmask = 0x3, mem_ready after 3 wait cycles -> mem_* held constant for 4 cycles, d_ack one cycle after mem_ready, busy low with ack.
- Simultaneous, macro undefined: i_req and d_req both high in cycle N -> D granted first; after d_ack, I granted; exactly two memory transactions in order D, I.
- Simultaneous, MEM_ARB_RR_EN defined: both requesters continuously re-requesting for 4 transactions -> grant order D, I, D, I.
- Timeout: TIMEOUT = 4, d_req load, mem_ready never -> d_ack with d_err = 1 and d_rdata = 0 after 4 grant cycles; mem_req drops; a subsequent i_req is served normally.
- Reset mid-grant: reset in the 2nd GRANT_I cycle -> next cycle all outputs 0, state IDLE, no i_ack. After release, a held i_req is re-issued.
